// File: rtl/seg_codes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_codes_pkg
// Description : Glyph constants, FSM state type and timing defaults shared by
//               the scanned seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_codes_pkg;

   localparam int c_SETTLE_DEFAULT  = 4;
   localparam int c_TIMEOUT_DEFAULT = 200000;

   // Active-low segment patterns, bit 0 = a ... bit 6 = g
   localparam logic [6:0] c_GLYPH_0 = 7'h40;
   localparam logic [6:0] c_GLYPH_1 = 7'h79;
   localparam logic [6:0] c_GLYPH_2 = 7'h24;
   localparam logic [6:0] c_GLYPH_3 = 7'h30;
   localparam logic [6:0] c_GLYPH_4 = 7'h19;
   localparam logic [6:0] c_GLYPH_5 = 7'h12;
   localparam logic [6:0] c_GLYPH_6 = 7'h02;
   localparam logic [6:0] c_GLYPH_7 = 7'h78;
   localparam logic [6:0] c_GLYPH_8 = 7'h00;
   localparam logic [6:0] c_GLYPH_9 = 7'h10;
   localparam logic [6:0] c_GLYPH_A = 7'h08;
   localparam logic [6:0] c_GLYPH_B = 7'h03;
   localparam logic [6:0] c_GLYPH_C = 7'h46;
   localparam logic [6:0] c_GLYPH_D = 7'h21;
   localparam logic [6:0] c_GLYPH_E = 7'h06;
   localparam logic [6:0] c_GLYPH_F = 7'h0e;

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_decode
// Description : Combinational lookup from a 7-bit active-low glyph to a hex
//               nibble, with a flag marking legal glyphs.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_decode
   import seg_codes_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_nibble,
   output logic       o_legal
);

   always_comb begin
      o_nibble = 4'h0;
      o_legal  = 1'b1;
      case (i_seg)
         c_GLYPH_0: o_nibble = 4'h0;
         c_GLYPH_1: o_nibble = 4'h1;
         c_GLYPH_2: o_nibble = 4'h2;
         c_GLYPH_3: o_nibble = 4'h3;
         c_GLYPH_4: o_nibble = 4'h4;
         c_GLYPH_5: o_nibble = 4'h5;
         c_GLYPH_6: o_nibble = 4'h6;
         c_GLYPH_7: o_nibble = 4'h7;
         c_GLYPH_8: o_nibble = 4'h8;
         c_GLYPH_9: o_nibble = 4'h9;
         c_GLYPH_A: o_nibble = 4'hA;
         c_GLYPH_B: o_nibble = 4'hB;
         c_GLYPH_C: o_nibble = 4'hC;
         c_GLYPH_D: o_nibble = 4'hD;
         c_GLYPH_E: o_nibble = 4'hE;
         c_GLYPH_F: o_nibble = 4'hF;
         default:   o_legal  = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Recovers an 8-digit hex frame plus decimal points from a
//               multiplexed seven-segment scan (SEL one-hot, SEG active-low).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
   import seg_codes_pkg::*;
#(
   parameter int SETTLE_CYCLES  = c_SETTLE_DEFAULT,
   parameter int TIMEOUT_CYCLES = c_TIMEOUT_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [7:0]  SEL,
   input  logic [7:0]  SEG,
   output logic [31:0] Disp_Data,
   output logic [7:0]  point_mask,
   output logic        frame_valid,
   output logic        code_err,
   output logic        sel_err
);

   localparam int c_SW = $clog2(SETTLE_CYCLES + 1);
   localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
   localparam logic [c_TW-1:0] c_TMO_MAX     = c_TW'(TIMEOUT_CYCLES);
   localparam logic [c_TW-1:0] c_TMO_LAST    = c_TW'(TIMEOUT_CYCLES - 1);

   logic [7:0]  r_sel_m, r_sel_s, r_sel_q;
   logic [7:0]  r_seg_m, r_seg_s, r_seg_q;
   scan_state_t r_state, w_state_nxt;
   logic [c_SW-1:0] r_settle;
   logic [c_TW-1:0] r_tmo;
   logic [2:0]  r_exp;
   logic        r_bad;
   logic [31:0] r_shadow, w_shadow_nxt, r_disp;
   logic [7:0]  r_shadow_dp, w_dp_nxt, r_pmask;
   logic        r_fvalid, r_sel_err;

   logic        w_sel_chg, w_seg_chg, w_tmo_hit, w_capture, w_commit;
   logic        w_err, w_frame_start, w_adv;
   logic [2:0]  w_exp_inc;
   logic [3:0]  w_nib;
   logic        w_legal;

   assign w_sel_chg = (r_sel_s != r_sel_q);
   assign w_seg_chg = (r_seg_s != r_seg_q);
   assign w_exp_inc = r_exp + 3'd1;
   assign w_tmo_hit = !w_sel_chg && (r_tmo == c_TMO_LAST);
   assign w_capture = (r_state == ST_CAPTURE);

   // r_seg_q holds the value that was proven stable by the settle count
   seg7_glyph_decode u_glyph (
      .i_seg    (r_seg_q[6:0]),
      .o_nibble (w_nib),
      .o_legal  (w_legal)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_err         = 1'b0;
      w_frame_start = 1'b0;
      w_adv         = 1'b0;
      case (r_state)
         ST_SYNC: begin
            if (w_sel_chg && (r_sel_s == 8'h01)) begin
               w_state_nxt   = ST_SETTLE;
               w_frame_start = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (w_sel_chg) begin
               if (r_sel_s != (8'd1 << r_exp)) w_err = 1'b1;
            end else if (!w_seg_chg && (r_settle == c_SETTLE_LAST)) begin
               w_state_nxt = ST_CAPTURE;
            end
         end
         default: begin
            w_state_nxt = ST_HOLD;
            if (w_sel_chg) begin
               if (r_sel_s == (8'd1 << w_exp_inc)) begin
                  w_state_nxt = ST_SETTLE;
                  w_adv       = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
      endcase
      if (w_tmo_hit) w_err = 1'b1;
      if (w_err) w_state_nxt = ST_SYNC;
   end

   always_comb begin
      w_shadow_nxt = r_shadow;
      w_dp_nxt     = r_shadow_dp;
      w_shadow_nxt[{r_exp, 2'b00} +: 4] = w_legal ? w_nib : 4'h0;
      w_dp_nxt[r_exp]                   = ~r_seg_q[7];
   end

   assign w_commit = w_capture && (r_exp == 3'd7) && !r_bad && w_legal && !w_err;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sel_m     <= 8'h00;
         r_sel_s     <= 8'h00;
         r_sel_q     <= 8'h00;
         r_seg_m     <= 8'h00;
         r_seg_s     <= 8'h00;
         r_seg_q     <= 8'h00;
         r_state     <= ST_SYNC;
         r_settle    <= '0;
         r_tmo       <= '0;
         r_exp       <= 3'd0;
         r_bad       <= 1'b0;
         r_shadow    <= 32'h0;
         r_shadow_dp <= 8'h00;
         r_disp      <= 32'h0;
         r_pmask     <= 8'h00;
         r_fvalid    <= 1'b0;
         r_sel_err   <= 1'b0;
      end else begin
         r_sel_m  <= SEL;
         r_sel_s  <= r_sel_m;
         r_sel_q  <= r_sel_s;
         r_seg_m  <= SEG;
         r_seg_s  <= r_seg_m;
         r_seg_q  <= r_seg_s;
         r_state  <= w_state_nxt;

         if ((r_state != ST_SETTLE) || w_sel_chg || w_seg_chg) r_settle <= '0;
         else                                                  r_settle <= r_settle + 1'b1;

         // Saturating so a stuck SEL reports exactly once
         if (w_sel_chg)               r_tmo <= '0;
         else if (r_tmo != c_TMO_MAX) r_tmo <= r_tmo + 1'b1;

         if (w_frame_start) r_exp <= 3'd0;
         else if (w_adv)    r_exp <= w_exp_inc;

         if (w_frame_start || (w_adv && (w_exp_inc == 3'd0))) r_bad <= 1'b0;
         else if (w_capture && !w_legal)                       r_bad <= 1'b1;

         if (w_capture) begin
            r_shadow    <= w_shadow_nxt;
            r_shadow_dp <= w_dp_nxt;
         end
         if (w_commit) begin
            r_disp  <= w_shadow_nxt;
            r_pmask <= w_dp_nxt;
         end
         r_fvalid  <= w_commit;
         r_sel_err <= w_err;
      end
   end

   assign Disp_Data   = r_disp;
   assign point_mask  = r_pmask;
   assign frame_valid = r_fvalid;
   assign sel_err     = r_sel_err;
   assign code_err    = w_capture && !w_legal;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Self-checking bench for seg_scan_decoder; expected frames are
//               queued when driven and compared on each frame_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 300;
   localparam int DWELL   = 50;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [7:0]  SEL;
   logic [7:0]  SEG;
   logic [31:0] Disp_Data;
   logic [7:0]  point_mask;
   logic        frame_valid, code_err, sel_err;

   int n_cmp = 0;
   int n_mis = 0;
   int n_ce  = 0;
   int n_se  = 0;
   logic [39:0] exp_q[$];

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      int          bad_digit;
      logic [31:0] exp_disp;
      logic [7:0]  exp_pm;
      int          exp_ce;
   } vec_t;
   vec_t tbl[5];

   seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .SEL         (SEL),
      .SEG         (SEG),
      .Disp_Data   (Disp_Data),
      .point_mask  (point_mask),
      .frame_valid (frame_valid),
      .code_err    (code_err),
      .sel_err     (sel_err)
   );

   always #5 Clk = ~Clk;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [7:0] g;
      case (n)
         4'h0: g = 8'hc0;  4'h1: g = 8'hf9;  4'h2: g = 8'ha4;  4'h3: g = 8'hb0;
         4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hf8;
         4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
         4'hC: g = 8'hc6;  4'hD: g = 8'ha1;  4'hE: g = 8'h86;  default: g = 8'h8e;
      endcase
      return g[6:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Scoreboard: pop one expected frame per frame_valid pulse
   always @(negedge Clk) begin
      if (Reset_n === 1'b1) begin
         if (code_err) n_ce++;
         if (sel_err)  n_se++;
         if (frame_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame_valid", {31'b0, frame_valid}, 32'h0);
            end else begin
               logic [39:0] e;
               e = exp_q.pop_front();
               check("frame_data", Disp_Data, e[39:8]);
               check("frame_pmask", {24'h0, point_mask}, {24'h0, e[7:0]});
            end
         end
      end
   end

   task automatic scan_digit(input int k, input logic [3:0] nib, input logic dp,
                             input bit bad, input bit glitch, input int dwell);
      SEL = 8'd1 << k;
      if (glitch) begin
         SEG = 8'hFF;
         repeat (3) @(posedge Clk);
         #1;
         dwell = dwell - 3;
      end
      SEG = {~dp, bad ? 7'h7f : glyph(nib)};
      repeat (dwell) @(posedge Clk);
      #1;
   endtask

   task automatic scan_frame(input logic [31:0] data, input logic [7:0] dp,
                             input int bad_digit, input int glitch_digit);
      if (bad_digit < 0) exp_q.push_back({data, dp});
      for (int k = 0; k < 8; k++)
         scan_digit(k, data[4*k +: 4], dp[k], (k == bad_digit), (k == glitch_digit), DWELL);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_disp"},  Disp_Data, 32'h0);
      check({tag, "_pmask"}, {24'h0, point_mask}, 32'h0);
      check({tag, "_fvalid"}, {31'b0, frame_valid}, 32'h0);
      check({tag, "_code_err"}, {31'b0, code_err}, 32'h0);
      check({tag, "_sel_err"}, {31'b0, sel_err}, 32'h0);
   endtask

   initial begin
      int ce0, se0;
      tbl[0] = '{32'h12345678, 8'h22, -1, 32'h12345678, 8'h22, 0};
      tbl[1] = '{32'hCAFEF00D, 8'h81,  3, 32'h12345678, 8'h22, 1};
      tbl[2] = '{32'hCAFEF00D, 8'h81, -1, 32'hCAFEF00D, 8'h81, 0};
      tbl[3] = '{32'h9ABCDEF0, 8'hFF, -1, 32'h9ABCDEF0, 8'hFF, 0};
      tbl[4] = '{32'h00000000, 8'h00, -1, 32'h00000000, 8'h00, 0};

      Reset_n = 1'b0;
      SEL = 8'h00;
      SEG = 8'hFF;
      #1;
      repeat (5) @(posedge Clk);
      #1;
      check_outputs_zero("reset");
      Reset_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         ce0 = n_ce;
         se0 = n_se;
         scan_frame(tbl[i].data, tbl[i].dp, tbl[i].bad_digit, -1);
         check($sformatf("vec%0d_disp", i), Disp_Data, tbl[i].exp_disp);
         check($sformatf("vec%0d_pmask", i), {24'h0, point_mask}, {24'h0, tbl[i].exp_pm});
         check($sformatf("vec%0d_code_err", i), n_ce - ce0, tbl[i].exp_ce);
         check($sformatf("vec%0d_sel_err", i), n_se - se0, 0);
      end

      // Short SEG glitch on digit 3 must be filtered by the settle count
      ce0 = n_ce;
      se0 = n_se;
      scan_frame(32'h13572468, 8'h10, -1, 3);
      check("glitch_disp", Disp_Data, 32'h13572468);
      check("glitch_code_err", n_ce - ce0, 0);
      check("glitch_sel_err", n_se - se0, 0);

      // Out-of-order digit: 01,02,08 then the rest of the scan, then a full frame
      se0 = n_se;
      scan_digit(0, 4'h1, 1'b0, 1'b0, 1'b0, DWELL);
      scan_digit(1, 4'h2, 1'b0, 1'b0, 1'b0, DWELL);
      for (int k = 3; k < 8; k++) scan_digit(k, 4'h5, 1'b0, 1'b0, 1'b0, DWELL);
      check("order_sel_err", n_se - se0, 1);
      check("order_disp_kept", Disp_Data, 32'h13572468);
      scan_frame(32'h87654321, 8'h0C, -1, -1);
      check("order_resync_disp", Disp_Data, 32'h87654321);

      // SEL stuck on digit 2: exactly one timeout error, then decoder is in SYNC
      se0 = n_se;
      scan_digit(0, 4'h3, 1'b0, 1'b0, 1'b0, DWELL);
      scan_digit(1, 4'h4, 1'b0, 1'b0, 1'b0, DWELL);
      scan_digit(2, 4'h5, 1'b0, 1'b0, 1'b0, TIMEOUT + 60);
      check("timeout_sel_err", n_se - se0, 1);
      se0 = n_se;
      for (int k = 3; k < 8; k++) scan_digit(k, 4'h6, 1'b0, 1'b0, 1'b0, DWELL);
      check("timeout_sync_quiet", n_se - se0, 0);
      scan_frame(32'h0F1E2D3C, 8'h5A, -1, -1);
      check("timeout_resync_disp", Disp_Data, 32'h0F1E2D3C);
      check("timeout_resync_pmask", {24'h0, point_mask}, 32'h5A);

      // Reset during digit 5 discards the partial frame
      for (int k = 0; k < 5; k++) scan_digit(k, 4'h7, 1'b0, 1'b0, 1'b0, DWELL);
      scan_digit(5, 4'h7, 1'b0, 1'b0, 1'b0, 20);
      #3;
      Reset_n = 1'b0;
      #2;
      check_outputs_zero("midreset");
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      scan_digit(5, 4'h7, 1'b0, 1'b0, 1'b0, 30);
      scan_digit(6, 4'h7, 1'b0, 1'b0, 1'b0, DWELL);
      scan_digit(7, 4'h7, 1'b0, 1'b0, 1'b0, DWELL);
      check("postreset_no_frame", Disp_Data, 32'h0);
      scan_frame(32'hDEADBEEF, 8'h0F, -1, -1);
      check("postreset_disp", Disp_Data, 32'hDEADBEEF);
      check("postreset_pmask", {24'h0, point_mask}, 32'h0F);

      check("pending_frames", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: number of consecutive stable synchronized cycles before a digit is sampled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000: cycles with no SEL change before the decoder resynchronizes.
REQ-003 Clk  input  1  system clock, rising edge.
REQ-004 Reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SEL  input  8  scanned digit select; one-hot, active-high; bit k is digit k.
REQ-006 SEG  input  8  scanned segment bus, active-low; bit 0 is segment a through bit 6 is segment g; bit 7 is the decimal point.
REQ-007 Disp_Data  output  32  last good frame; digit k occupies bits [4k+3:4k].
REQ-008 point_mask  output  8  last good frame decimal points; bit k=1 means the dp of digit k was lit (SEG[7]=0).
REQ-009 frame_valid  output  1  one-cycle pulse when Disp_Data and point_mask update.
REQ-010 code_err  output  1  one-cycle pulse when a sampled SEG[6:0] is not a legal hex glyph.
REQ-011 sel_err  output  1  one-cycle pulse on a non-one-hot SEL, an out-of-order digit, or a timeout.

Function
REQ-012 SEL and SEG SHALL pass through a 2-flop synchronizer; all further logic SHALL use the synchronized copies.
REQ-013 Glyph table, SEG[6:0] to nibble: c0=0, f9=1, a4=2, b0=3, 99=4, 92=5, 82=6, f8=7, 80=8, 90=9, 88=A, 83=b, c6=C, a1=d, 86=E, 8e=F; all other values are illegal.
REQ-014 FSM states SHALL be SYNC, SETTLE, CAPTURE and HOLD.
REQ-015 SYNC: wait for the synchronized SEL to change to 8'h01, then go to SETTLE with expected digit 0 and the frame-bad flag cleared.
REQ-016 SETTLE: count cycles in which both SEL and SEG are unchanged; any change restarts the count; at SETTLE_CYCLES go to CAPTURE.
REQ-017 CAPTURE (single cycle): write the decoded nibble and dp into the shadow slot for the expected digit, then go to HOLD.
REQ-018 HOLD: on a SEL change to the next one-hot (expected+1), go to SETTLE.
REQ-019 HOLD after digit 7: on a SEL change to 8'h01, start the next frame.
REQ-020 A SEL value that is not one-hot, or a one-hot value other than the expected digit, SHALL pulse sel_err and go to SYNC; shadow contents are discarded.
REQ-021 An illegal glyph SHALL pulse code_err in the CAPTURE cycle, store nibble 0 and set frame-bad; scanning continues.
REQ-022 At the CAPTURE of digit 7 with frame-bad clear, Disp_Data and point_mask SHALL load from the shadow and frame_valid SHALL pulse in the next cycle (capture-to-output latency 1 cycle).
REQ-023 If frame-bad is set at digit 7, the outputs SHALL keep their old values and frame_valid SHALL stay low.
REQ-024 A timeout counter SHALL reset on every SEL change; on reaching TIMEOUT_CYCLES it SHALL pulse sel_err and go to SYNC, and it SHALL saturate rather than wrap.
REQ-025 A SEL change in the same cycle as settle-count completion SHALL take priority: restart SETTLE with no capture.
REQ-026 A SEL of 8'h00 SHALL be treated as non-one-hot.
REQ-027 In SYNC no error is flagged, except by the timeout.

Reset
REQ-028 On Reset_n low, all outputs SHALL go to 0: Disp_Data=0, point_mask=0, and frame_valid, code_err and sel_err low.
REQ-029 On Reset_n low, the FSM SHALL go to SYNC and the synchronizers, counters, shadow and frame-bad SHALL clear.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first frame_valid after release requires a complete new frame.

Structure
REQ-031 A shared package seg_codes_pkg SHALL hold the 16 glyph constants, the FSM state typedef and the SETTLE/TIMEOUT defaults.
REQ-032 The glyph lookup SHALL be a combinational sub-module seg7_glyph_decode: 7-bit in; 4-bit nibble and a legal flag out.

Verification
REQ-033 Scan 0x12345678 with dp on digits 1 and 5, SETTLE_CYCLES=4, dwell 50 cycles per digit: frame_valid after the first full frame, Disp_Data=32'h12345678, point_mask=8'h22.
REQ-034 Digit 3 glyph = 7'h7f during one frame: code_err pulses once, no frame_valid for that frame, outputs unchanged; the next clean frame updates them.
REQ-035 SEL sequence 01,02,08: sel_err at 08 and resync; the first frame_valid comes only after a full 01..80 sequence.
REQ-036 SEL held at 8'h04 for TIMEOUT_CYCLES: exactly one sel_err pulse, FSM in SYNC.
REQ-037 Reset_n pulsed low during digit 5: outputs read 0; a complete frame 0xDEADBEEF then gives Disp_Data=32'hDEADBEEF.
REQ-038 SEG glitch on a digit 3 cycles long (below SETTLE_CYCLES): settle restarts, the captured value is the final stable glyph, no error.
